// File: rtl/seq_verify_param.sv
// Parametrised ASCII sequence verifier.
// Checks NUL-framed character frames against LETTERS{MIN_ALPHA..MAX_ALPHA}
// followed by DIGITS{MIN_DIGIT..MAX_DIGIT}. For each frame it reports a
// verdict, an error cause, a running match counter and a strobe that is
// stretched to one UART TX bit period.

module seq_verify_param #(
    parameter int FREQ         = 200,
    parameter int UART_TX_baud = 20,
    parameter int MIN_ALPHA    = 2,
    parameter int MAX_ALPHA    = 2,
    parameter int MIN_DIGIT    = 3,
    parameter int MAX_DIGIT    = 3,
    parameter int CASE_INSENS  = 0,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ascii_char,
    input  logic             char_valid,
    output logic             sequence_valid,
    output logic             output_strobe,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] match_count,
    output logic             in_frame
);

    // Strobe length in clock cycles, one TX bit period.
    localparam int TX_DIV = FREQ / UART_TX_baud;
    localparam int SW     = (TX_DIV > 1) ? $clog2(TX_DIV + 1) : 1;

    // Counters hold MAX+1 as a sticky "too many" value.
    localparam int AW = $clog2(MAX_ALPHA + 2);
    localparam int DW = $clog2(MAX_DIGIT + 2);
    localparam logic [AW-1:0] ALPHA_SAT = AW'(MAX_ALPHA + 1);
    localparam logic [DW-1:0] DIGIT_SAT = DW'(MAX_DIGIT + 1);

    localparam logic [1:0] CAUSE_OK    = 2'd0;
    localparam logic [1:0] CAUSE_CHAR  = 2'd1;
    localparam logic [1:0] CAUSE_ALPHA = 2'd2;
    localparam logic [1:0] CAUSE_DIGIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ALPHA,
        DIGIT,
        ERR
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     alpha_cnt_q;
    logic [DW-1:0]     digit_cnt_q;
    logic              has_char_q;
    logic              seq_valid_q;
    logic              strobe_q;
    logic [SW-1:0]     strobe_cnt_q;
    logic [1:0]        err_q;
    logic [CNT_W-1:0]  match_q;

    logic              is_nul;
    logic              is_letter;
    logic              is_digit;
    logic [AW-1:0]     alpha_cnt_d;
    logic [DW-1:0]     digit_cnt_d;
    logic [1:0]        cause_d;

    // Classify the incoming character; lowercase counts as a letter only
    // when the case-insensitive variant is selected.
    always_comb begin
        is_nul    = (ascii_char == 8'h00);
        is_digit  = (ascii_char >= 8'h30) && (ascii_char <= 8'h39);
        is_letter = ((ascii_char >= 8'h41) && (ascii_char <= 8'h5A)) ||
                    ((CASE_INSENS != 0) &&
                     (ascii_char >= 8'h61) && (ascii_char <= 8'h7A));
    end

    // Saturating increments so overlong runs never wrap back into range.
    always_comb begin
        alpha_cnt_d = (alpha_cnt_q == ALPHA_SAT) ? alpha_cnt_q
                                                 : alpha_cnt_q + AW'(1);
        digit_cnt_d = (digit_cnt_q == DIGIT_SAT) ? digit_cnt_q
                                                 : digit_cnt_q + DW'(1);
    end

    // Verdict cause for the frame being closed, highest priority first.
    always_comb begin
        cause_d = CAUSE_OK;
        if (state_q == ERR) begin
            cause_d = CAUSE_CHAR;
        end else if ((int'(alpha_cnt_q) < MIN_ALPHA) ||
                     (int'(alpha_cnt_q) > MAX_ALPHA)) begin
            cause_d = CAUSE_ALPHA;
        end else if ((int'(digit_cnt_q) < MIN_DIGIT) ||
                     (int'(digit_cnt_q) > MAX_DIGIT)) begin
            cause_d = CAUSE_DIGIT;
        end
    end

    // Frame FSM, counters, verdict registers and strobe stretcher.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            alpha_cnt_q  <= '0;
            digit_cnt_q  <= '0;
            has_char_q   <= 1'b0;
            seq_valid_q  <= 1'b0;
            strobe_q     <= 1'b0;
            strobe_cnt_q <= '0;
            err_q        <= CAUSE_OK;
            match_q      <= '0;
        end else begin
            if (strobe_q) begin
                if (strobe_cnt_q == '0) begin
                    strobe_q <= 1'b0;
                end else begin
                    strobe_cnt_q <= strobe_cnt_q - SW'(1);
                end
            end

            if (char_valid) begin
                if (is_nul) begin
                    if ((state_q != IDLE) && has_char_q) begin
                        seq_valid_q  <= (cause_d == CAUSE_OK);
                        err_q        <= cause_d;
                        strobe_q     <= 1'b1;
                        strobe_cnt_q <= SW'(TX_DIV - 1);
                        if (cause_d == CAUSE_OK) begin
                            match_q <= match_q + CNT_W'(1);
                        end
                    end
                    state_q     <= ALPHA;
                    alpha_cnt_q <= '0;
                    digit_cnt_q <= '0;
                    has_char_q  <= 1'b0;
                end else begin
                    case (state_q)
                        IDLE: begin
                        end
                        ALPHA: begin
                            has_char_q <= 1'b1;
                            if (is_letter) begin
                                alpha_cnt_q <= alpha_cnt_d;
                            end else if (is_digit) begin
                                digit_cnt_q <= DW'(1);
                                state_q     <= DIGIT;
                            end else begin
                                state_q <= ERR;
                            end
                        end
                        DIGIT: begin
                            has_char_q <= 1'b1;
                            if (is_digit) begin
                                digit_cnt_q <= digit_cnt_d;
                            end else begin
                                state_q <= ERR;
                            end
                        end
                        ERR: begin
                            has_char_q <= 1'b1;
                        end
                        default: begin
                            state_q <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign sequence_valid = seq_valid_q;
    assign output_strobe  = strobe_q;
    assign err_code       = err_q;
    assign match_count    = match_q;
    assign in_frame       = (state_q != IDLE);

endmodule
